// File: rtl/regfile_scan.sv
// regfile_scan: parametrised 2-read/1-write register file whose storage is also one serial scan chain.
// Optional write-through forwarding to both read ports when REGFILE_BYPASS_EN is defined.
module regfile_scan #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned ZERO_REG = 0,
  parameter int unsigned AW       = $clog2(DEPTH)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Test,
  input  logic             SDI,
  output logic             SDO,
  input  logic             RegWe,
  input  logic [AW-1:0]    Rw,
  input  logic [WIDTH-1:0] Wd,
  input  logic [AW-1:0]    Rs1,
  input  logic [AW-1:0]    Rs2,
  output logic [WIDTH-1:0] Rd1,
  output logic [WIDTH-1:0] Rd2
);

  localparam int unsigned B = (ZERO_REG != 0) ? 1 : 0;
  localparam int unsigned N = (DEPTH - B) * WIDTH;

  // Register i (i >= B) lives at r_chain[(i-B)*WIDTH +: WIDTH]; bit 0 is the scan output end.
  logic [N-1:0]     r_chain;
  logic [N-1:0]     w_shift;
  logic             w_wr_ok;
  logic             w_we;
  logic [WIDTH-1:0] w_rd1;
  logic [WIDTH-1:0] w_rd2;

  generate
    if (N == 1) begin : g_shift1
      assign w_shift = SDI;
    end else begin : g_shiftn
      assign w_shift = {SDI, r_chain[N-1:1]};
    end
  endgenerate

  always_comb begin
    w_wr_ok = 1'b0;
    for (int unsigned i = B; i < DEPTH; i++) begin
      if (Rw == AW'(i)) w_wr_ok = 1'b1;
    end
  end

  assign w_we = RegWe & ~Test & w_wr_ok;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_chain <= '0;
    end else if (Test) begin
      r_chain <= w_shift;
    end else if (w_we) begin
      for (int unsigned i = B; i < DEPTH; i++) begin
        if (Rw == AW'(i)) r_chain[(i-B)*WIDTH +: WIDTH] <= Wd;
      end
    end
  end

  // Unmatched addresses (hardwired zero or beyond DEPTH) fall through to the zero default.
  always_comb begin
    w_rd1 = '0;
    w_rd2 = '0;
    for (int unsigned i = B; i < DEPTH; i++) begin
      if (Rs1 == AW'(i)) w_rd1 = r_chain[(i-B)*WIDTH +: WIDTH];
      if (Rs2 == AW'(i)) w_rd2 = r_chain[(i-B)*WIDTH +: WIDTH];
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic w_fwd;
  // Forwarding is masked during reset so reads stay zero while storage is held clear.
  assign w_fwd = w_we & ~Reset;
  assign Rd1   = (w_fwd && (Rs1 == Rw)) ? Wd : w_rd1;
  assign Rd2   = (w_fwd && (Rs2 == Rw)) ? Wd : w_rd2;
`else
  assign Rd1   = w_rd1;
  assign Rd2   = w_rd2;
`endif

  assign SDO = r_chain[0];

endmodule

// File: tb/tb_regfile_scan.sv
// Self-checking bench for regfile_scan: default 16x8 instance plus an 8x6 ZERO_REG=1 instance
// driven by the same stimulus and checked against an array/queue reference model.
module tb_regfile_scan;
  timeunit 1ns;
  timeprecision 1ps;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        Clock;
  logic        Reset;
  logic        Test;
  logic        SDI;
  logic        RegWe;
  logic [2:0]  Rw;
  logic [15:0] Wd;
  logic [2:0]  Rs1;
  logic [2:0]  Rs2;
  logic        SDO;
  logic [15:0] Rd1;
  logic [15:0] Rd2;
  logic        SDO_z;
  logic [7:0]  Rd1_z;
  logic [7:0]  Rd2_z;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] m_reg [8];
  logic [7:0]  z_reg [6];

  regfile_scan #(.WIDTH(16), .DEPTH(8), .ZERO_REG(0)) u_dut (
    .Clock(Clock), .Reset(Reset), .Test(Test), .SDI(SDI), .SDO(SDO),
    .RegWe(RegWe), .Rw(Rw), .Wd(Wd), .Rs1(Rs1), .Rs2(Rs2), .Rd1(Rd1), .Rd2(Rd2)
  );

  regfile_scan #(.WIDTH(8), .DEPTH(6), .ZERO_REG(1)) u_dut_z (
    .Clock(Clock), .Reset(Reset), .Test(Test), .SDI(SDI), .SDO(SDO_z),
    .RegWe(RegWe), .Rw(Rw), .Wd(Wd[7:0]), .Rs1(Rs1), .Rs2(Rs2), .Rd1(Rd1_z), .Rd2(Rd2_z)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic logic [15:0] m_read(input logic [2:0] a);
    if (BYP && RegWe && !Test && !Reset && a == Rw) return Wd;
    return m_reg[a];
  endfunction

  function automatic logic [7:0] z_read(input logic [2:0] a);
    if (a == 3'd0 || a >= 3'd6) return 8'h00;
    if (BYP && RegWe && !Test && !Reset && a == Rw) return Wd[7:0];
    return z_reg[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m_reg[i] = '0;
    for (int i = 0; i < 6; i++) z_reg[i] = '0;
  endtask

  // Apply the effect of the coming rising edge to the model, using the inputs now applied.
  task automatic model_edge();
    bit mq[$];
    bit zq[$];
    if (Test) begin
      for (int r = 0; r < 8; r++) for (int b = 0; b < 16; b++) mq.push_back(m_reg[r][b]);
      for (int r = 1; r < 6; r++) for (int b = 0; b < 8; b++) zq.push_back(z_reg[r][b]);
      void'(mq.pop_front());
      void'(zq.pop_front());
      mq.push_back(SDI);
      zq.push_back(SDI);
      for (int k = 0; k < 128; k++) m_reg[k / 16][k % 16] = mq[k];
      for (int k = 0; k < 40; k++) z_reg[1 + k / 8][k % 8] = zq[k];
    end else if (RegWe) begin
      m_reg[Rw] = Wd;
      if (Rw >= 3'd1 && Rw <= 3'd5) z_reg[Rw] = Wd[7:0];
    end
  endtask

  task automatic clk_step();
    model_edge();
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    Test = 0;
    for (int i = 0; i < 8; i++) begin
      RegWe = 1; Rw = 3'(i); Wd = 16'($urandom);
      clk_step();
    end
    RegWe = 0;
    @(negedge Clock);
    Reset = 1;
    model_clear();
    for (int a = 0; a < 8; a++) begin
      Rs1 = 3'(a); Rs2 = 3'(7 - a);
      #0.1;
      n_checks++;
      if (Rd1 !== 16'h0000 || Rd2 !== 16'h0000) begin
        n_fail++; $display("FAIL reset_rd a=%0d: got %h/%h expected 0000/0000", a, Rd1, Rd2);
      end
      n_checks++;
      if (Rd1_z !== 8'h00 || Rd2_z !== 8'h00) begin
        n_fail++; $display("FAIL reset_rd_z a=%0d: got %h/%h expected 00/00", a, Rd1_z, Rd2_z);
      end
    end
    n_checks++;
    if (SDO !== 1'b0 || SDO_z !== 1'b0) begin
      n_fail++; $display("FAIL reset_sdo: got %b/%b expected 0/0", SDO, SDO_z);
    end
    Reset = 0;
    #1;
  endtask

  task automatic test_write_read();
    Test = 0; RegWe = 1; Rw = 3'd3; Wd = 16'hA5C3; Rs1 = 3'd3; Rs2 = 3'd0;
    #1;
    n_checks++;
    if (Rd1 !== (BYP ? 16'hA5C3 : 16'h0000)) begin
      n_fail++; $display("FAIL wr_pre_edge: got %h expected %h", Rd1, BYP ? 16'hA5C3 : 16'h0000);
    end
    clk_step();
    RegWe = 0;
    #1;
    n_checks++;
    if (Rd1 !== 16'hA5C3 || Rd2 !== 16'h0000) begin
      n_fail++; $display("FAIL wr_post_edge: got %h/%h expected a5c3/0000", Rd1, Rd2);
    end
    n_checks++;
    if (Rd1_z !== 8'hC3 || Rd2_z !== 8'h00) begin
      n_fail++; $display("FAIL wr_post_edge_z: got %h/%h expected c3/00", Rd1_z, Rd2_z);
    end
  endtask

  task automatic test_bypass();
    logic [15:0] old_m;
    logic [7:0]  old_z;
    old_m = m_reg[5];
    old_z = z_reg[5];
    Test = 0; RegWe = 1; Rw = 3'd5; Rs1 = 3'd5; Rs2 = 3'd5; Wd = 16'hBEEF;
    #1;
    n_checks++;
    if (Rd1 !== (BYP ? 16'hBEEF : old_m) || Rd2 !== (BYP ? 16'hBEEF : old_m)) begin
      n_fail++; $display("FAIL bypass_pre: got %h/%h expected %h", Rd1, Rd2, BYP ? 16'hBEEF : old_m);
    end
    n_checks++;
    if (Rd1_z !== (BYP ? 8'hEF : old_z) || Rd2_z !== (BYP ? 8'hEF : old_z)) begin
      n_fail++; $display("FAIL bypass_pre_z: got %h/%h expected %h", Rd1_z, Rd2_z, BYP ? 8'hEF : old_z);
    end
    clk_step();
    RegWe = 0;
    #1;
    n_checks++;
    if (Rd1 !== 16'hBEEF || Rd2_z !== 8'hEF) begin
      n_fail++; $display("FAIL bypass_post: got %h/%h expected beef/ef", Rd1, Rd2_z);
    end
  endtask

  task automatic test_random(input int cycles, input int test_pct);
    for (int c = 0; c < cycles; c++) begin
      Test  = ($urandom_range(99) < test_pct);
      SDI   = 1'($urandom);
      RegWe = 1'($urandom);
      Rw    = 3'($urandom);
      Wd    = 16'($urandom);
      Rs1   = 3'($urandom);
      Rs2   = 3'($urandom);
      #1;
      n_checks++;
      if (Rd1 !== m_read(Rs1) || Rd2 !== m_read(Rs2)) begin
        n_fail++; $display("FAIL rand_rd c=%0d: got %h/%h expected %h/%h", c, Rd1, Rd2, m_read(Rs1), m_read(Rs2));
      end
      n_checks++;
      if (Rd1_z !== z_read(Rs1) || Rd2_z !== z_read(Rs2)) begin
        n_fail++; $display("FAIL rand_rd_z c=%0d: got %h/%h expected %h/%h", c, Rd1_z, Rd2_z, z_read(Rs1), z_read(Rs2));
      end
      n_checks++;
      if (SDO !== m_reg[0][0] || SDO_z !== z_reg[1][0]) begin
        n_fail++; $display("FAIL rand_sdo c=%0d: got %b/%b expected %b/%b", c, SDO, SDO_z, m_reg[0][0], z_reg[1][0]);
      end
      clk_step();
    end
    Test = 0; RegWe = 0;
  endtask

  task automatic test_scan_dump();
    logic [15:0] v;
    Test = 0;
    for (int i = 0; i < 8; i++) begin
      RegWe = 1; Rw = 3'(i); Wd = 16'(16'h1111 * i);
      clk_step();
    end
    RegWe = 0; Test = 1; SDI = 0;
    for (int k = 0; k < 128; k++) begin
      #1;
      v = 16'(16'h1111 * (k / 16));
      n_checks++;
      if (SDO !== v[k % 16]) begin
        n_fail++; $display("FAIL scan_dump k=%0d: got %b expected %b", k, SDO, v[k % 16]);
      end
      if (k < 40) begin
        n_checks++;
        if (SDO_z !== z_reg[1][0]) begin
          n_fail++; $display("FAIL scan_dump_z k=%0d: got %b expected %b", k, SDO_z, z_reg[1][0]);
        end
      end
      clk_step();
    end
    Test = 0;
    for (int a = 0; a < 8; a++) begin
      Rs1 = 3'(a); Rs2 = 3'(a);
      #1;
      n_checks++;
      if (Rd1 !== 16'h0000 || Rd2 !== 16'h0000 || Rd1_z !== 8'h00) begin
        n_fail++; $display("FAIL scan_empty a=%0d: got %h/%h/%h expected 0", a, Rd1, Rd2, Rd1_z);
      end
    end
  endtask

  task automatic test_test_priority();
    Test = 0; RegWe = 1; Rw = 3'd1; Wd = 16'h0003;
    clk_step();
    Rw = 3'd2; Wd = 16'h1234;
    clk_step();
    Test = 1; RegWe = 1; Rw = 3'd2; Wd = 16'hFFFF; SDI = 1;
    clk_step();
    Test = 0; RegWe = 0; Rs1 = 3'd2; Rs2 = 3'd0;
    #1;
    n_checks++;
    if (Rd1 !== 16'h091A || Rd2 !== 16'h8000) begin
      n_fail++; $display("FAIL prio_r2_r0: got %h/%h expected 091a/8000", Rd1, Rd2);
    end
    Rs1 = 3'd1; Rs2 = 3'd7;
    #1;
    n_checks++;
    if (Rd1 !== 16'h0001 || Rd2 !== 16'h8000) begin
      n_fail++; $display("FAIL prio_r1_r7: got %h/%h expected 0001/8000", Rd1, Rd2);
    end
    Rs1 = 3'd2; Rs2 = 3'd5;
    #1;
    n_checks++;
    if (Rd1_z !== 8'h1A || Rd2_z !== 8'h80) begin
      n_fail++; $display("FAIL prio_z: got %h/%h expected 1a/80", Rd1_z, Rd2_z);
    end
  endtask

  task automatic test_zero_reg();
    logic [39:0] pat;
    Test = 0; RegWe = 1; Rw = 3'd0; Wd = 16'h1234;
    clk_step();
    Rw = 3'd6; Wd = 16'hFFFF;
    clk_step();
    RegWe = 0; Rs1 = 3'd0; Rs2 = 3'd6;
    #1;
    n_checks++;
    if (Rd1_z !== 8'h00 || Rd2_z !== 8'h00) begin
      n_fail++; $display("FAIL zero_reg_z: got %h/%h expected 00/00", Rd1_z, Rd2_z);
    end
    n_checks++;
    if (Rd1 !== 16'h1234 || Rd2 !== 16'hFFFF) begin
      n_fail++; $display("FAIL zero_reg_main: got %h/%h expected 1234/ffff", Rd1, Rd2);
    end
    pat = {8'($urandom), 32'($urandom)};
    Test = 1;
    for (int t = 0; t < 40; t++) begin
      SDI = pat[t];
      clk_step();
    end
    Test = 0;
    for (int a = 1; a < 6; a++) begin
      Rs1 = 3'(a);
      #1;
      n_checks++;
      if (Rd1_z !== pat[(a - 1) * 8 +: 8]) begin
        n_fail++; $display("FAIL zero_load a=%0d: got %h expected %h", a, Rd1_z, pat[(a - 1) * 8 +: 8]);
      end
    end
    n_checks++;
    if (SDO_z !== pat[0] || Rd1 !== m_read(Rs1)) begin
      n_fail++; $display("FAIL zero_load_sdo: got %b/%h expected %b/%h", SDO_z, Rd1, pat[0], m_read(Rs1));
    end
  endtask

  task automatic test_reset_mid_scan();
    logic [15:0] v;
    Test = 1;
    for (int i = 0; i < 5; i++) begin
      SDI = 1;
      clk_step();
    end
    @(negedge Clock);
    Reset = 1;
    model_clear();
    Rs1 = 3'd7; Rs2 = 3'd5;
    #1;
    n_checks++;
    if (Rd1 !== 16'h0000 || Rd2_z !== 8'h00 || SDO !== 1'b0 || SDO_z !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_scan: got %h/%h/%b/%b expected 0", Rd1, Rd2_z, SDO, SDO_z);
    end
    @(negedge Clock);
    Reset = 0;
    v = 16'($urandom);
    Test = 0; RegWe = 1; Rw = 3'd4; Wd = v;
    clk_step();
    RegWe = 0; Rs1 = 3'd4; Rs2 = 3'd4;
    #1;
    n_checks++;
    if (Rd1 !== v || Rd2_z !== v[7:0]) begin
      n_fail++; $display("FAIL post_reset_write: got %h/%h expected %h/%h", Rd1, Rd2_z, v, v[7:0]);
    end
  endtask

  initial begin
    Reset = 1; Test = 0; SDI = 0; RegWe = 0; Rw = '0; Wd = '0; Rs1 = '0; Rs2 = 3'd7;
    model_clear();
    #1;
    n_checks++;
    if (Rd1 !== 16'h0000 || Rd2 !== 16'h0000 || SDO !== 1'b0 || Rd1_z !== 8'h00) begin
      n_fail++; $display("FAIL init_reset: got %h/%h/%b/%h expected 0", Rd1, Rd2, SDO, Rd1_z);
    end
    @(negedge Clock);
    Reset = 0;
    test_reset();
    test_write_read();
    test_bypass();
    test_random(150, 0);
    test_scan_dump();
    test_test_priority();
    test_zero_reg();
    test_random(300, 35);
    test_reset_mid_scan();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
